// File: rtl/maple_pkg.sv
// maple_pkg
// Shared definitions for the Maple bus encoder/decoder pair: the receive
// state encoding, the default frame timeout and the byte width.
package maple_pkg;

    localparam int TIMEOUT_DEFAULT = 64;
    localparam int BYTE_W          = 8;
    localparam int BIT_CNT_W       = $clog2(BYTE_W);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BUS = 3'd1,
        PHASE1   = 3'd2,
        PHASE2   = 3'd3,
        FLUSH    = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/maple_line_sync.sv
// maple_line_sync
// Brings one asynchronous Maple bus line into the clk domain and detects
// edges on the synchronized value.
//   clk    : system clock
//   reset  : asynchronous active-low reset (flops preset to 1, the idle level)
//   line   : raw bus line
//   level  : synchronized line value
//   fall   : one-cycle pulse on a synchronized falling edge
//   toggle : one-cycle pulse on any synchronized edge
module maple_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic fall,
    output logic toggle
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '1;
            prev_reg <= 1'b1;
        end else begin
            // Shift the raw line in at bit 0; the oldest sample drops off the top.
            sync_reg <= SYNC_STAGES'({sync_reg, line});
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level  = sync_reg[SYNC_STAGES-1];
    assign fall   = prev_reg & ~level;
    assign toggle = prev_reg ^ level;

endmodule

// File: rtl/data_decoder.sv
// data_decoder
// Receives one Maple bus frame per enable and streams the bytes out on an
// AXI-Stream master port, marking the final byte with TLAST.
//   clk                 : system clock, all logic on posedge
//   reset               : asynchronous active-low reset
//   enable              : arms reception of one frame while idle
//   sdcka, sdckb        : Maple bus lines (asynchronous)
//   M_AXIS_TVALID/TREADY/TLAST/TDATA : received byte stream
//   done                : one-cycle pulse at frame end
//   frame_err, overflow, crc_error : sticky status, cleared on a new enable
// Optional feature: define DATA_DECODER_CRC_EN to build the XOR checksum
// check; otherwise crc_error is constant 0.
module data_decoder
    import maple_pkg::*;
#(
    parameter int TIMEOUT     = TIMEOUT_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sdcka,
    input  logic              sdckb,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic              M_AXIS_TLAST,
    output logic [BYTE_W-1:0] M_AXIS_TDATA,
    output logic              done,
    output logic              frame_err,
    output logic              overflow,
    output logic              crc_error
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t state_reg, state_next;

    logic a_level, a_fall, a_edge;
    logic b_level, b_fall, b_edge;

    logic [BYTE_W-1:0]    shift_reg;
    logic [BYTE_W-1:0]    pend_reg;
    logic                 pend_valid_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_reg;
    logic [TO_W-1:0]      to_cnt_reg;
    logic [BYTE_W-1:0]    tdata_reg;
    logic                 tvalid_reg;
    logic                 tlast_reg;
    logic                 frame_err_reg;
    logic                 overflow_reg;

    logic arm, do_sample, sample_bit, flush_fire;
    logic timed_out, out_free, byte_wrap, move_req, load_move, drop_move;
    logic load_flush, load_en;
    logic [BYTE_W-1:0] shift_next;

    maple_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk    (clk),
        .reset  (reset),
        .line   (sdcka),
        .level  (a_level),
        .fall   (a_fall),
        .toggle (a_edge)
    );

    maple_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk    (clk),
        .reset  (reset),
        .line   (sdckb),
        .level  (b_level),
        .fall   (b_fall),
        .toggle (b_edge)
    );

    assign timed_out  = (to_cnt_reg == TO_W'(TIMEOUT));
    assign out_free   = !tvalid_reg || M_AXIS_TREADY;
    assign shift_next = {shift_reg[BYTE_W-2:0], sample_bit};
    assign byte_wrap  = do_sample && (bit_cnt_reg == '1);
    // The held byte leaves pending when the first bit of the next byte arrives.
    assign move_req   = do_sample && (bit_cnt_reg == '0) && pend_valid_reg;
    assign load_move  = move_req && out_free;
    assign drop_move  = move_req && !out_free;
    assign load_flush = flush_fire && pend_valid_reg;
    assign load_en    = load_move || load_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        arm        = 1'b0;
        do_sample  = 1'b0;
        sample_bit = 1'b0;
        flush_fire = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    arm        = 1'b1;
                    state_next = WAIT_BUS;
                end
            end
            WAIT_BUS: begin
                if (a_level && b_level) begin
                    state_next = PHASE1;
                end
            end
            PHASE1: begin
                if (timed_out) begin
                    state_next = FLUSH;
                end else if (a_fall) begin
                    do_sample  = 1'b1;
                    sample_bit = b_level;
                    state_next = PHASE2;
                end
            end
            PHASE2: begin
                if (timed_out) begin
                    state_next = FLUSH;
                end else if (b_fall) begin
                    do_sample  = 1'b1;
                    sample_bit = a_level;
                    state_next = PHASE1;
                end
            end
            FLUSH: begin
                // Never drop the final byte: wait for the output slot.
                if (out_free) begin
                    flush_fire = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Idle counter: restarts on any synchronized edge, saturates at TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_reg <= '0;
        end else if ((state_reg == PHASE1 || state_reg == PHASE2) && !(a_edge || b_edge)) begin
            if (!timed_out) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
        end else begin
            to_cnt_reg <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg      <= '0;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            bit_cnt_reg    <= '0;
            tdata_reg      <= '0;
            tvalid_reg     <= 1'b0;
            tlast_reg      <= 1'b0;
            frame_err_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            if (load_en) begin
                tdata_reg  <= pend_reg;
                tlast_reg  <= load_flush;
                tvalid_reg <= 1'b1;
            end else if (tvalid_reg && M_AXIS_TREADY) begin
                tvalid_reg <= 1'b0;
            end

            if (arm) begin
                shift_reg      <= '0;
                pend_valid_reg <= 1'b0;
                bit_cnt_reg    <= '0;
                frame_err_reg  <= 1'b0;
                overflow_reg   <= 1'b0;
            end else begin
                if (do_sample) begin
                    shift_reg   <= shift_next;
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
                if (byte_wrap) begin
                    pend_reg       <= shift_next;
                    pend_valid_reg <= 1'b1;
                end else if (move_req || flush_fire) begin
                    pend_valid_reg <= 1'b0;
                end
                if (drop_move) begin
                    overflow_reg <= 1'b1;
                end
                if (flush_fire) begin
                    bit_cnt_reg <= '0;
                    // A partial byte or a frame with no bytes is malformed.
                    if (bit_cnt_reg != '0 || !pend_valid_reg) begin
                        frame_err_reg <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef DATA_DECODER_CRC_EN
    logic [BYTE_W-1:0] crc_acc_reg;
    logic              crc_error_reg;

    // Only bytes that actually reach the output register are accumulated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_acc_reg   <= '0;
            crc_error_reg <= 1'b0;
        end else if (arm) begin
            crc_acc_reg   <= '0;
            crc_error_reg <= 1'b0;
        end else begin
            if (load_en) begin
                crc_acc_reg <= crc_acc_reg ^ pend_reg;
            end
            if (state_reg == DONE && crc_acc_reg != '0) begin
                crc_error_reg <= 1'b1;
            end
        end
    end

    assign crc_error = crc_error_reg;
`else
    assign crc_error = 1'b0;
`endif

    assign M_AXIS_TVALID = tvalid_reg;
    assign M_AXIS_TLAST  = tlast_reg;
    assign M_AXIS_TDATA  = tdata_reg;
    assign done          = (state_reg == DONE);
    assign frame_err     = frame_err_reg;
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_data_decoder.sv
// tb_data_decoder
// Directed bench for data_decoder: a table of frames with hand-computed
// beats and status, followed by reset-mid-frame and glitch sequences.
module tb_data_decoder;

    localparam int TIMEOUT = 64;
`ifdef DATA_DECODER_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       sdcka = 1'b1;
    logic       sdckb = 1'b1;
    logic       tready = 1'b1;
    logic       tvalid, tlast, done, frame_err, overflow, crc_error;
    logic [7:0] tdata;

    always #5 clk = ~clk;

    data_decoder #(.TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .sdcka         (sdcka),
        .sdckb         (sdckb),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TREADY (tready),
        .M_AXIS_TLAST  (tlast),
        .M_AXIS_TDATA  (tdata),
        .done          (done),
        .frame_err     (frame_err),
        .overflow      (overflow),
        .crc_error     (crc_error)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_data[$];
    logic       cap_last[$];
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (tvalid && tready) begin
            cap_data.push_back(tdata);
            cap_last.push_back(tlast);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int phase = 0;

    // Phase 1 bits: B carries data, A falls. Phase 2 bits: A carries data, B falls.
    task automatic send_bit(input logic b);
        if (phase == 0) begin
            sdcka = 1'b1; sdckb = b;
            tick(4);
            sdcka = 1'b0;
            tick(4);
        end else begin
            sdckb = 1'b1; sdcka = b;
            tick(4);
            sdckb = 1'b0;
            tick(4);
        end
        phase ^= 1;
    endtask

    task automatic send_byte(input logic [7:0] v, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) send_bit(v[i]);
    endtask

    task automatic start_frame();
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        phase = 0;
        tick(3);
    endtask

    task automatic wait_done(input int base, input string name);
        int n;
        n = 0;
        while (done_cnt == base && n < 400) begin
            tick(1);
            n++;
        end
        tick(3);
        check({name, " done pulses"}, done_cnt - base, 1);
    endtask

    typedef struct {
        int              nbytes;
        logic [0:2][7:0] bytes;
        logic [7:0]      pbyte;
        int              pbits;
        logic            rdy;
        int              nbeats;
        logic [0:2][7:0] edata;
        logic [0:2]      elast;
        logic            ferr;
        logic            ovf;
    } vec_t;

    function automatic logic exp_crc(input vec_t v);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < v.nbeats; i++) x ^= v.edata[i];
        return CRC_EN && (x != 8'h00);
    endfunction

    vec_t vecs[7];

    initial begin
        int bb, db;

        vecs[0] = '{nbytes:2, bytes:{8'hA5, 8'h3C, 8'h00}, pbyte:8'h00, pbits:0, rdy:1'b1,
                    nbeats:2, edata:{8'hA5, 8'h3C, 8'h00}, elast:3'b010, ferr:1'b0, ovf:1'b0};
        vecs[1] = '{nbytes:1, bytes:{8'h5A, 8'h00, 8'h00}, pbyte:8'h96, pbits:5, rdy:1'b1,
                    nbeats:1, edata:{8'h5A, 8'h00, 8'h00}, elast:3'b000, ferr:1'b1, ovf:1'b0};
        vecs[2] = '{nbytes:0, bytes:{8'h00, 8'h00, 8'h00}, pbyte:8'h00, pbits:0, rdy:1'b1,
                    nbeats:0, edata:{8'h00, 8'h00, 8'h00}, elast:3'b000, ferr:1'b1, ovf:1'b0};
        vecs[3] = '{nbytes:3, bytes:{8'h01, 8'h02, 8'h03}, pbyte:8'h00, pbits:0, rdy:1'b1,
                    nbeats:3, edata:{8'h01, 8'h02, 8'h03}, elast:3'b001, ferr:1'b0, ovf:1'b0};
        vecs[4] = '{nbytes:3, bytes:{8'h01, 8'h02, 8'h07}, pbyte:8'h00, pbits:0, rdy:1'b1,
                    nbeats:3, edata:{8'h01, 8'h02, 8'h07}, elast:3'b001, ferr:1'b0, ovf:1'b0};
        vecs[5] = '{nbytes:3, bytes:{8'h11, 8'h22, 8'h33}, pbyte:8'h00, pbits:0, rdy:1'b0,
                    nbeats:2, edata:{8'h11, 8'h33, 8'h00}, elast:3'b010, ferr:1'b0, ovf:1'b1};
        vecs[6] = '{nbytes:0, bytes:{8'h00, 8'h00, 8'h00}, pbyte:8'hA0, pbits:3, rdy:1'b1,
                    nbeats:0, edata:{8'h00, 8'h00, 8'h00}, elast:3'b000, ferr:1'b1, ovf:1'b0};

        // Reset state
        tick(3);
        check("reset tvalid", tvalid, 0);
        check("reset tlast", tlast, 0);
        check("reset tdata", tdata, 0);
        check("reset done", done, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overflow", overflow, 0);
        check("reset crc_error", crc_error, 0);
        @(negedge clk) reset = 1'b1;
        tick(2);

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            tready = vecs[v].rdy;
            bb = cap_data.size();
            db = done_cnt;
            start_frame();
            for (int i = 0; i < vecs[v].nbytes; i++) send_byte(vecs[v].bytes[i], 8);
            if (vecs[v].pbits > 0) send_byte(vecs[v].pbyte, vecs[v].pbits);
            sdcka = 1'b1; sdckb = 1'b1;
            if (!vecs[v].rdy) begin
                tick(TIMEOUT + 60);
                check($sformatf("vec%0d held flush no done", v), done_cnt - db, 0);
                tready = 1'b1;
            end
            wait_done(db, $sformatf("vec%0d", v));
            check($sformatf("vec%0d beat count", v), cap_data.size() - bb, vecs[v].nbeats);
            for (int i = 0; i < vecs[v].nbeats; i++) begin
                if (bb + i < cap_data.size()) begin
                    check($sformatf("vec%0d beat%0d tdata", v, i), cap_data[bb+i], vecs[v].edata[i]);
                    check($sformatf("vec%0d beat%0d tlast", v, i), cap_last[bb+i], vecs[v].elast[i]);
                end
            end
            check($sformatf("vec%0d frame_err", v), frame_err, vecs[v].ferr);
            check($sformatf("vec%0d overflow", v), overflow, vecs[v].ovf);
            check($sformatf("vec%0d crc_error", v), crc_error, exp_crc(vecs[v]));
            $display("vec %0d: beats=%0d frame_err=%0b overflow=%0b crc_error=%0b",
                     v, cap_data.size() - bb, frame_err, overflow, crc_error);
        end

        // Reset during bit 3 of the second byte, with the first byte held at the output
        tready = 1'b0;
        bb = cap_data.size();
        db = done_cnt;
        start_frame();
        send_byte(8'hC3, 8);
        send_byte(8'h00, 3);
        check("rst held tvalid", tvalid, 1);
        check("rst held tdata", tdata, 8'hC3);
        check("rst held tlast", tlast, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst async tvalid", tvalid, 0);
        check("rst async done", done, 0);
        check("rst async overflow", overflow, 0);
        tick(2);
        sdcka = 1'b1; sdckb = 1'b1; tready = 1'b1;
        @(negedge clk) reset = 1'b1;
        tick(2);
        check("rst no beat", cap_data.size() - bb, 0);
        check("rst no done", done_cnt - db, 0);
        $display("reset mid-frame: tvalid=%0b", tvalid);

        bb = cap_data.size();
        db = done_cnt;
        start_frame();
        send_byte(8'hFF, 8);
        sdcka = 1'b1; sdckb = 1'b1;
        wait_done(db, "post-rst");
        check("post-rst beat count", cap_data.size() - bb, 1);
        if (bb < cap_data.size()) begin
            check("post-rst tdata", cap_data[bb], 8'hFF);
            check("post-rst tlast", cap_last[bb], 1);
        end
        check("post-rst frame_err", frame_err, 0);
        check("post-rst overflow", overflow, 0);
        check("post-rst crc_error", crc_error, CRC_EN);
        $display("post-reset frame: beats=%0d", cap_data.size() - bb);

        // Sub-cycle glitch on sdcka while waiting for the bus to go idle-high
        sdcka = 1'b0;
        tick(4);
        bb = cap_data.size();
        db = done_cnt;
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        tick(3);
        @(posedge clk);
        #3 sdcka = 1'b1;
        #4 sdcka = 1'b0;
        tick(6);
        sdcka = 1'b1;
        tick(3);
        phase = 0;
        send_byte(8'h3C, 8);
        sdcka = 1'b1; sdckb = 1'b1;
        wait_done(db, "glitch");
        check("glitch beat count", cap_data.size() - bb, 1);
        if (bb < cap_data.size()) begin
            check("glitch tdata", cap_data[bb], 8'h3C);
            check("glitch tlast", cap_last[bb], 1);
        end
        check("glitch frame_err", frame_err, 0);
        $display("glitch frame: beats=%0d frame_err=%0b", cap_data.size() - bb, frame_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_decoder.md
DATA_DECODER -- requirements
Module: data_decoder

Interface
REQ-001 Parameter TIMEOUT, default 64: idle clk cycles with no line edge that end a frame.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on sdcka/sdckb.
REQ-003 clk  input  1  single clock, all logic on posedge.
REQ-004 reset  input  1  asynchronous, active-low; one clock, reset asynchronous active-low.
REQ-005 enable  input  1  arms reception of one frame when IDLE.
REQ-006 sdcka, sdckb  input  1 each  Maple bus lines, asynchronous to clk.
REQ-007 M_AXIS_TVALID  output  1; M_AXIS_TREADY  input  1; M_AXIS_TLAST  output  1; M_AXIS_TDATA  output  8  received byte stream.
REQ-008 done  output  1  one-cycle pulse at frame end.
REQ-009 frame_err, overflow, crc_error  output  1 each  sticky status, cleared when enable is sampled in IDLE.

Function
REQ-010 Both lines SHALL pass through SYNC_STAGES flops; edges are detected on synchronized values only (latency SYNC_STAGES+1 cycles).
REQ-011 States SHALL be IDLE, WAIT_BUS, PHASE1, PHASE2, FLUSH, DONE.
REQ-012 IDLE->WAIT_BUS on enable; WAIT_BUS->PHASE1 once both lines are high in the same cycle.
REQ-013 PHASE1: on sdcka falling edge, sample sdckb as next bit -> PHASE2.
REQ-014 PHASE2: on sdckb falling edge, sample sdcka as next bit -> PHASE1.
REQ-015 Bits SHALL shift in MSB first; a 3-bit counter wraps 7->0, and each wrap completes one byte.
REQ-016 A completed byte SHALL enter a pending register; pending moves to the output register with TLAST=0 when the next byte's first bit is sampled.
REQ-017 The timeout counter SHALL reset on any synchronized edge; in PHASE1/PHASE2, reaching TIMEOUT -> FLUSH.
REQ-018 FLUSH with counter==0 and pending valid: pending moves to output with TLAST=1, then DONE.
REQ-019 FLUSH with counter!=0: partial byte discarded, frame_err set, pending (if any) emitted with TLAST=1, then DONE.
REQ-020 FLUSH with no pending and counter==0 (empty frame): nothing emitted, frame_err set, then DONE.
REQ-021 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-022 Output register: TVALID held until TVALID&&TREADY; TDATA/TLAST stable while TVALID&&!TREADY.
REQ-023 A move into the output register is allowed when TVALID is low or TREADY is high in that same cycle.
REQ-024 If a move is required while the output is still held, the moved byte SHALL be dropped and overflow set; reception continues.
REQ-025 FLUSH SHALL wait in FLUSH (no drop) until the output register is free.
REQ-026 enable is ignored outside IDLE; edges on the lines are ignored in IDLE/DONE.

Reset
REQ-027 Reset asserted: state IDLE, TVALID=0, TLAST=0, TDATA=0, done=0, all status=0, counters/pending cleared, synchronizers set to 1.
REQ-028 Reset mid-frame SHALL drop all partial/pending/output data immediately, with no done pulse.

Configuration
REQ-029 Macro DATA_DECODER_CRC_EN defined: XOR of all emitted frame bytes is accumulated; at DONE, crc_error is set if the XOR is nonzero (last byte is the checksum).
REQ-030 Macro DATA_DECODER_CRC_EN undefined: no accumulator is built and crc_error is tied to 0.

Structure
REQ-031 Shared package maple_pkg SHALL hold the state enum, the TIMEOUT default and the byte width constant; it is shared with the encoder.
REQ-032 Sub-module maple_line_sync (synchronizer plus falling-edge detect, one per line) SHALL be instantiated twice.

Verification
REQ-033 Encoder-style waveform of bytes 0xA5, 0x3C, then idle for TIMEOUT -> two beats 0xA5/TLAST=0 and 0x3C/TLAST=1, then one done pulse.
REQ-034 Bytes 0x01, 0x02, 0x03 (checksum 0x00) with CRC_EN -> crc_error=0; checksum changed to 0x07 -> crc_error=1.
REQ-035 TREADY held low across three bytes -> first byte retained, the byte needing the slot dropped, overflow=1, done still pulses.
REQ-036 Timeout after 5 bits of the second byte -> first byte emitted with TLAST=1, frame_err=1.
REQ-037 Reset asserted during bit 3 -> TVALID=0 and state IDLE within the same clock; next enable receives 0xFF cleanly.
REQ-038 Single-cycle glitch (shorter than one clk) on sdcka in WAIT_BUS -> no bit sampled, no error.
